// File: rtl/hilo_pkg.sv
// Shared encodings for the E-stage HI/LO controller: op classes, mul/div unit
// op codes and controller FSM states.
package hilo_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  // Must match the op codes understood by the mul/div unit.
  localparam logic [1:0] MD_IDLE = 2'b00;
  localparam logic [1:0] MD_MUL  = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  function automatic logic [1:0] md_op_of(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU: md_op_of = MD_MUL;
      OP_DIV, OP_DIVU:   md_op_of = MD_DIV;
      default:           md_op_of = MD_IDLE;
    endcase
  endfunction

  function automatic logic is_md_op(input logic [3:0] op);
    is_md_op = (md_op_of(op) != MD_IDLE);
  endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// HI/LO register file and mul/div issue controller for the E stage: launches
// mult/div, captures the 64-bit result and serves mfhi/mflo/mthi/mtlo.
module hilo_ctrl
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_op,
  input  logic        e_kill,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        md_in_valid,
  input  logic        md_in_ready,
  output logic [1:0]  md_in_op,
  output logic        md_in_sign,
  output logic [31:0] md_src0,
  output logic [31:0] md_src1,
  input  logic        md_out_valid,
  output logic        md_out_ready,
  input  logic [31:0] md_res0,
  input  logic [31:0] md_res1
);

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic live;
  logic is_md;
  logic is_hilo;

  assign md_src0 = e_rs;
  assign md_src1 = e_rt;

  always_comb begin
    live         = e_valid & ~e_kill & ~reset;
    is_md        = is_md_op(e_op);
    is_hilo      = (e_op != OP_NONE);
    md_in_sign   = (e_op == OP_MULT) | (e_op == OP_DIV);

    md_in_valid  = live & is_md & (state_q == ST_IDLE);
    md_in_op     = md_in_valid ? md_op_of(e_op) : MD_IDLE;
    md_out_ready = ~reset & (state_q == ST_WAIT);
    // Any HI/LO op waits out an in-flight result, so moves and reads never race the capture.
    stall        = live & is_hilo & ((state_q == ST_WAIT) | (is_md & ~md_in_ready));

    rd_data = '0;
    if (!reset) begin
      if (e_op == OP_MFHI) rd_data = hi_q;
      else if (e_op == OP_MFLO) rd_data = lo_q;
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (md_in_valid && md_in_ready) state_d = ST_WAIT;
        if (live && !stall && e_op == OP_MTHI) hi_d = e_rs;
        if (live && !stall && e_op == OP_MTLO) lo_d = e_rs;
      end
      ST_WAIT: begin
        if (md_out_valid) begin
          hi_d    = md_res1;
          lo_d    = md_res0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: behavioural mul/div unit, table of E-stage instructions
// with expected read data and stall counts, plus ready/reset corner sequences.
module tb_hilo_ctrl;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_op;
  logic        e_kill;
  logic [31:0] e_rs, e_rt;
  logic        stall;
  logic [31:0] rd_data;
  logic        md_in_valid, md_in_ready;
  logic [1:0]  md_in_op;
  logic        md_in_sign;
  logic [31:0] md_src0, md_src1;
  logic        md_out_valid, md_out_ready;
  logic [31:0] md_res0, md_res1;

  always #5 clk = ~clk;

  hilo_ctrl dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_op(e_op), .e_kill(e_kill),
    .e_rs(e_rs), .e_rt(e_rt), .stall(stall), .rd_data(rd_data),
    .md_in_valid(md_in_valid), .md_in_ready(md_in_ready), .md_in_op(md_in_op),
    .md_in_sign(md_in_sign), .md_src0(md_src0), .md_src1(md_src1),
    .md_out_valid(md_out_valid), .md_out_ready(md_out_ready),
    .md_res0(md_res0), .md_res1(md_res1)
  );

  // Mul/div unit model: multiply answers the cycle after launch, divide four cycles after.
  localparam int DIV_CNT   = 3;
  localparam int DIV_STALL = DIV_CNT + 1;

  logic ready_en;
  logic busy;
  int   cnt;
  int   launch_cnt;
  int   cap_cnt;

  assign md_in_ready = ready_en & ~busy;

  function automatic logic [63:0] unit_calc(input logic [1:0] op, input logic sgn,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb;
    int          ia, ib;
    if (op == MD_MUL) begin
      sa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
      sb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
      unit_calc = sa * sb;
    end else if (b == 32'd0) begin
      unit_calc = {a, 32'hFFFF_FFFF};
    end else if (sgn) begin
      ia = a;
      ib = b;
      unit_calc = {32'(ia % ib), 32'(ia / ib)};
    end else begin
      unit_calc = {a % b, a / b};
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      busy         <= 1'b0;
      md_out_valid <= 1'b0;
      cnt          <= 0;
    end else if (md_in_valid && md_in_ready) begin
      {md_res1, md_res0} <= unit_calc(md_in_op, md_in_sign, md_src0, md_src1);
      launch_cnt <= launch_cnt + 1;
      busy       <= 1'b1;
      if (md_in_op == MD_MUL) md_out_valid <= 1'b1;
      else cnt <= DIV_CNT;
    end else if (busy && !md_out_valid) begin
      if (cnt <= 1) md_out_valid <= 1'b1;
      else cnt <= cnt - 1;
    end else if (md_out_valid && md_out_ready) begin
      md_out_valid <= 1'b0;
      busy         <= 1'b0;
      cap_cnt      <= cap_cnt + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        kill;
    logic [31:0] exp;
    int          exp_stall;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                              input logic kill, input logic [31:0] exp, input int st);
    vec_t v;
    v.op = op; v.rs = rs; v.rt = rt; v.kill = kill; v.exp = exp; v.exp_stall = st;
    return v;
  endfunction

  // Holds one instruction in E until it leaves, counting stall cycles.
  task automatic issue(input vec_t v, input string nm);
    int  stalls;
    bit  done;
    int  l0;
    logic [31:0] e;
    e_valid = 1'b1; e_op = v.op; e_rs = v.rs; e_rt = v.rt; e_kill = v.kill;
    if (v.op == OP_MFHI || v.op == OP_MFLO) exp_q.push_back(v.exp);
    l0 = launch_cnt;
    stalls = 0;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
      else begin
        stalls++;
        @(posedge clk);
      end
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout: stall still 1 after 50 cycles, required 0", nm);
    end else begin
      if (v.op == OP_MFHI || v.op == OP_MFLO) begin
        e = exp_q.pop_front();
        chk({nm, " rd_data"}, 64'(rd_data), 64'(e));
      end
      if (v.kill) chk({nm, " killed md_in_valid"}, 64'(md_in_valid), 64'd0);
    end
    if (v.exp_stall >= 0) chk({nm, " stall cycles"}, 64'(stalls), 64'(v.exp_stall));
    @(posedge clk);
    #1;
    if (v.kill) chk({nm, " killed launches"}, 64'(launch_cnt - l0), 64'd0);
    e_valid = 1'b0; e_op = OP_NONE; e_kill = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, c0;
    reset = 1'b1; e_valid = 1'b0; e_op = OP_NONE; e_kill = 1'b0; e_rs = '0; e_rt = '0;
    ready_en = 1'b1; launch_cnt = 0; cap_cnt = 0;

    tbl.push_back(mk(OP_MULT,  32'hFFFF_FFFF, 32'd2,        1'b0, 32'h0,         0));
    tbl.push_back(mk(OP_MFHI,  32'h0,         32'h0,        1'b0, 32'hFFFF_FFFF, 1));
    tbl.push_back(mk(OP_MFLO,  32'h0,         32'h0,        1'b0, 32'hFFFF_FFFE, 0));
    tbl.push_back(mk(OP_DIVU,  32'd7,         32'd2,        1'b0, 32'h0,         0));
    tbl.push_back(mk(OP_MFLO,  32'h0,         32'h0,        1'b0, 32'd3,         DIV_STALL));
    tbl.push_back(mk(OP_MFHI,  32'h0,         32'h0,        1'b0, 32'd1,         0));
    tbl.push_back(mk(OP_DIV,   32'hFFFF_FFF9, 32'd2,        1'b0, 32'h0,         0));
    tbl.push_back(mk(OP_MFLO,  32'h0,         32'h0,        1'b0, 32'hFFFF_FFFD, DIV_STALL));
    tbl.push_back(mk(OP_MFHI,  32'h0,         32'h0,        1'b0, 32'hFFFF_FFFF, 0));
    tbl.push_back(mk(OP_DIV,   32'd100,       32'd3,        1'b1, 32'h0,         0));
    tbl.push_back(mk(OP_MFLO,  32'h0,         32'h0,        1'b0, 32'hFFFF_FFFD, 0));
    tbl.push_back(mk(OP_MTLO,  32'hDEAD_0001, 32'h0,        1'b1, 32'h0,         0));
    tbl.push_back(mk(OP_MFLO,  32'h0,         32'h0,        1'b0, 32'hFFFF_FFFD, 0));
    tbl.push_back(mk(OP_DIVU,  32'd100,       32'd7,        1'b0, 32'h0,         0));
    tbl.push_back(mk(OP_MTLO,  32'h1234_5678, 32'h0,        1'b0, 32'h0,         DIV_STALL));
    tbl.push_back(mk(OP_MFLO,  32'h0,         32'h0,        1'b0, 32'h1234_5678, 0));
    tbl.push_back(mk(OP_MFHI,  32'h0,         32'h0,        1'b0, 32'd2,         0));
    tbl.push_back(mk(OP_MTHI,  32'hAABB_CCDD, 32'h0,        1'b0, 32'h0,         0));
    tbl.push_back(mk(OP_NONE,  32'h0,         32'h0,        1'b0, 32'h0,         0));
    tbl.push_back(mk(OP_MFHI,  32'h0,         32'h0,        1'b0, 32'hAABB_CCDD, 0));
    tbl.push_back(mk(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0,        0));
    tbl.push_back(mk(OP_MFHI,  32'h0,         32'h0,        1'b0, 32'hFFFF_FFFE, 1));
    tbl.push_back(mk(OP_MFLO,  32'h0,         32'h0,        1'b0, 32'h0000_0001, 0));
    tbl.push_back(mk(OP_DIVU,  32'd5,         32'd0,        1'b0, 32'h0,         0));
    tbl.push_back(mk(OP_MFLO,  32'h0,         32'h0,        1'b0, 32'hFFFF_FFFF, DIV_STALL));
    tbl.push_back(mk(OP_MFHI,  32'h0,         32'h0,        1'b0, 32'd5,         0));

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    e_valid = 1'b1; e_op = OP_MFHI;
    @(negedge clk);
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset rd_data HI", 64'(rd_data), 64'd0);
    chk("reset md_in_valid", 64'(md_in_valid), 64'd0);
    chk("reset md_out_ready", 64'(md_out_ready), 64'd0);
    chk("reset md_in_op", 64'(md_in_op), 64'd0);
    @(posedge clk);
    #1 e_valid = 1'b0; e_op = OP_NONE;

    for (int i = 0; i < tbl.size(); i++) issue(tbl[i], $sformatf("vec%0d", i));

    // Launch held off by md_in_ready=0, then a single launch and capture.
    l0 = launch_cnt; c0 = cap_cnt;
    ready_en = 1'b0;
    e_valid = 1'b1; e_op = OP_MULTU; e_rs = 32'd3; e_rt = 32'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("notready stall", 64'(stall), 64'd1);
      chk("notready md_in_valid", 64'(md_in_valid), 64'd1);
      @(posedge clk);
    end
    #1;
    chk("notready launches", 64'(launch_cnt - l0), 64'd0);
    ready_en = 1'b1;
    @(negedge clk);
    chk("ready stall", 64'(stall), 64'd0);
    chk("ready md_in_op", 64'(md_in_op), 64'(MD_MUL));
    @(posedge clk);
    #1 e_valid = 1'b0; e_op = OP_NONE;
    issue(mk(OP_MFLO, 32'h0, 32'h0, 1'b0, 32'd15, 1), "ready mflo");
    issue(mk(OP_MFHI, 32'h0, 32'h0, 1'b0, 32'd0, 0), "ready mfhi");
    chk("ready launch count", 64'(launch_cnt - l0), 64'd1);
    chk("ready capture count", 64'(cap_cnt - c0), 64'd1);

    // Reset while a divide is outstanding.
    issue(mk(OP_MTHI, 32'h5555_AAAA, 32'h0, 1'b0, 32'h0, 0), "pre-reset mthi");
    issue(mk(OP_DIVU, 32'd9, 32'd2, 1'b0, 32'h0, 0), "pre-reset divu");
    @(negedge clk);
    chk("wait md_out_ready", 64'(md_out_ready), 64'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    e_valid = 1'b1; e_op = OP_MFHI;
    @(negedge clk);
    chk("midreset stall", 64'(stall), 64'd0);
    chk("midreset md_out_ready", 64'(md_out_ready), 64'd0);
    chk("midreset HI", 64'(rd_data), 64'd0);
    e_op = OP_MFLO;
    #1 chk("midreset LO", 64'(rd_data), 64'd0);
    @(posedge clk);
    #1 e_valid = 1'b0; e_op = OP_NONE;
    repeat (6) @(posedge clk);
    #1 chk("midreset no late capture", 64'(md_out_valid), 64'd0);
    issue(mk(OP_MFHI, 32'h0, 32'h0, 1'b0, 32'd0, 0), "post-reset mfhi");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
